// File: rtl/mem_stage_dcache_pkg.sv
// mem_stage_dcache_pkg: shared state encoding, bus widths and address-field helpers for the MEM-stage data cache.
package mem_stage_dcache_pkg;
    localparam int BUS_W = 32;
    localparam int STRB_W = BUS_W / 8;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, DONE} state_t;
    function automatic logic [BUS_W-1:0] mask(input int w);
        return (BUS_W'(1) << w) - BUS_W'(1);
    endfunction
    function automatic logic [BUS_W-1:0] word_of(input logic [BUS_W-1:0] a, input int off_w);
        return (a >> 2) & mask(off_w);
    endfunction
    function automatic logic [BUS_W-1:0] idx_of(input logic [BUS_W-1:0] a, input int off_w, input int idx_w);
        return (a >> (off_w + 2)) & mask(idx_w);
    endfunction
    function automatic logic [BUS_W-1:0] tag_of(input logic [BUS_W-1:0] a, input int idx_w, input int off_w);
        return a >> (idx_w + off_w + 2);
    endfunction
    function automatic logic [BUS_W-1:0] line_of(input logic [BUS_W-1:0] a, input int off_w);
        return a & ~mask(off_w + 2);
    endfunction
endpackage

// File: rtl/mem_stage_dcache_if.sv
// mem_stage_dcache_if: valid/ready memory bus between the data cache (master) and backing memory (slave).
interface mem_stage_dcache_if;
    import mem_stage_dcache_pkg::*;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [BUS_W-1:0]  mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_rvalid;
    logic [BUS_W-1:0]  mem_rdata;
    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_dcache_array.sv
// mem_stage_dcache_array: valid/tag/data storage with a combinational read port, byte-merging word write and line install.
module mem_stage_dcache_array import mem_stage_dcache_pkg::*; #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int IDX_W = 4,
    parameter int OFF_W = 2,
    parameter int TAG_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [BUS_W-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              inst_en,
    input  logic [IDX_W-1:0]  inst_idx,
    input  logic [TAG_W-1:0]  inst_tag
);
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag [LINES];
    logic [BUS_W-1:0] data [LINES][WORDS];
    assign rd_valid = valid[rd_idx];
    assign rd_tag = tag[rd_idx];
    assign rd_data = data[rd_idx][rd_word];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid <= '0;
        else if (inst_en) valid[inst_idx] <= 1'b1;
    end
    // Tag and data carry no reset; the valid bits alone gate every hit.
    always_ff @(posedge clk) begin
        if (inst_en) tag[inst_idx] <= inst_tag;
        if (wr_en)
            for (int b = 0; b < STRB_W; b++)
                if (wr_strb[b]) data[wr_idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
    end
endmodule

// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped, write-through, no-write-allocate MEM-stage data cache.
// Stalls the pipeline on load misses and all stores; refills whole lines one word per beat.
module mem_stage_dcache import mem_stage_dcache_pkg::*; #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    localparam int IDX_W = $clog2(LINES),
    localparam int OFF_W = $clog2(WORDS),
    localparam int TAG_W = BUS_W - IDX_W - OFF_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [BUS_W-1:0]  cpu_addr,
    input  logic [BUS_W-1:0]  cpu_wdata,
    input  logic [STRB_W-1:0] cpu_wstrb,
    output logic [BUS_W-1:0]  cpu_rdata,
    output logic              cacheStall,
    mem_stage_dcache_if.master mem
);
    state_t state, nxt;
    logic [BUS_W-1:0] a_q, wd_q, lk, rd_data;
    logic [STRB_W-1:0] ws_q;
    logic [OFF_W-1:0] cnt;
    logic [TAG_W-1:0] rd_tag;
    logic rd_valid, hit, go, fill, last;
    // Lookups use the live CPU address when idle and the latched request otherwise.
    assign lk = (state == IDLE) ? cpu_addr : a_q;
    assign hit = rd_valid && rd_tag == TAG_W'(tag_of(lk, IDX_W, OFF_W));
    assign go = state == IDLE && cpu_req && (cpu_we || !hit);
    assign fill = state == RD_DATA && mem.mem_rvalid;
    assign last = fill && cnt == OFF_W'(WORDS - 1);
    assign cacheStall = state inside {RD_REQ, RD_DATA, WR_REQ} || go;
    assign cpu_rdata = (state == IDLE && hit) ? rd_data : '0;
    assign mem.mem_req_valid = state inside {RD_REQ, WR_REQ};
    assign mem.mem_we = state == WR_REQ;
    assign mem.mem_addr = a_q;
    assign mem.mem_wdata = wd_q;
    assign mem.mem_wstrb = ws_q;
    mem_stage_dcache_array #(
        .LINES(LINES), .WORDS(WORDS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (IDX_W'(idx_of(lk, OFF_W, IDX_W))),
        .rd_word  (OFF_W'(word_of(lk, OFF_W))),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill || (state == WR_REQ && mem.mem_req_ready && hit)),
        .wr_idx   (IDX_W'(idx_of(a_q, OFF_W, IDX_W))),
        .wr_word  (fill ? cnt : OFF_W'(word_of(a_q, OFF_W))),
        .wr_data  (fill ? mem.mem_rdata : wd_q),
        .wr_strb  (fill ? '1 : ws_q),
        .inst_en  (last),
        .inst_idx (IDX_W'(idx_of(a_q, OFF_W, IDX_W))),
        .inst_tag (TAG_W'(tag_of(a_q, IDX_W, OFF_W)))
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? (cpu_we ? WR_REQ : RD_REQ) : IDLE;
            RD_REQ:  nxt = mem.mem_req_ready ? RD_DATA : RD_REQ;
            RD_DATA: nxt = last ? IDLE : RD_DATA;
            WR_REQ:  nxt = mem.mem_req_ready ? DONE : WR_REQ;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_q <= '0;
            wd_q <= '0;
            ws_q <= '0;
            cnt <= '0;
        end else begin
            state <= nxt;
            if (go) begin
                a_q <= cpu_we ? cpu_addr : line_of(cpu_addr, OFF_W);
                wd_q <= cpu_wdata;
                ws_q <= cpu_wstrb;
                cnt <= '0;
            end else if (fill) cnt <= cnt + OFF_W'(1);
        end
    end
endmodule
